// File: rtl/rv32_lsu.sv
// Load/store unit bridging the RV32 core data port to a req/ack bus.
// Define RV32_LSU_MISALIGN_TRAP_EN to reject misaligned/illegal-size accesses.
module rv32_lsu #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] address,
    input  logic          MemRead,
    input  logic          MemWrite,
    input  logic [2:0]    funct3,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic          stall,
    output logic          lsu_err,
    output logic          bus_req,
    output logic          bus_we,
    output logic [AW-1:0] bus_addr,
    output logic [3:0]    bus_be,
    output logic [DW-1:0] bus_wdata,
    input  logic          bus_ack,
    input  logic [DW-1:0] bus_rdata
);

`ifdef RV32_LSU_MISALIGN_TRAP_EN
    typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;
`else
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
`endif

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    state_t state_q, state_d;

    logic          req;
    logic [1:0]    size_dec;
    logic          sign_dec;
    logic [3:0]    be_dec;
    logic [DW-1:0] wdata_dec;
    logic [DW-1:0] load_ext;
    logic [7:0]    byte_sel;
    logic [15:0]   half_sel;

    logic          bus_req_q, bus_req_d;
    logic          bus_we_q, bus_we_d;
    logic [AW-1:0] bus_addr_q, bus_addr_d;
    logic [3:0]    bus_be_q, bus_be_d;
    logic [DW-1:0] bus_wdata_q, bus_wdata_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [1:0]    size_q, size_d;
    logic          sign_q, sign_d;
    logic [1:0]    off_q, off_d;
    logic          store_q, store_d;

`ifdef RV32_LSU_MISALIGN_TRAP_EN
    logic misalign;
    logic lsu_err_q, lsu_err_d;
`endif

    assign req = MemRead | MemWrite;

    // Decode size, signedness, lane enables and replicated store data from the core request.
    always_comb begin
        size_dec  = SZ_WORD;
        sign_dec  = ~funct3[2];
        be_dec    = 4'b1111;
        wdata_dec = wdata;
        case (funct3[1:0])
            2'b00: begin
                size_dec  = SZ_BYTE;
                be_dec    = 4'b0001 << address[1:0];
                wdata_dec = {4{wdata[7:0]}};
            end
            2'b01: begin
                size_dec  = SZ_HALF;
                be_dec    = address[1] ? 4'b1100 : 4'b0011;
                wdata_dec = {2{wdata[15:0]}};
            end
            default: begin
                size_dec  = SZ_WORD;
                be_dec    = 4'b1111;
                wdata_dec = wdata;
            end
        endcase
    end

`ifdef RV32_LSU_MISALIGN_TRAP_EN
    // funct3 011/110/111 have no legal RV32 encoding and trap alongside misalignment.
    always_comb begin
        misalign = 1'b0;
        if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111)
            misalign = 1'b1;
        else if (size_dec == SZ_HALF && address[0])
            misalign = 1'b1;
        else if (size_dec == SZ_WORD && address[1:0] != 2'b00)
            misalign = 1'b1;
    end
`endif

    always_comb begin
        byte_sel = bus_rdata[7:0];
        case (off_q)
            2'd0:    byte_sel = bus_rdata[7:0];
            2'd1:    byte_sel = bus_rdata[15:8];
            2'd2:    byte_sel = bus_rdata[23:16];
            default: byte_sel = bus_rdata[31:24];
        endcase
        half_sel = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (size_q)
            SZ_BYTE: load_ext = {{24{sign_q & byte_sel[7]}}, byte_sel};
            SZ_HALF: load_ext = {{16{sign_q & half_sel[15]}}, half_sel};
            default: load_ext = bus_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req) begin
`ifdef RV32_LSU_MISALIGN_TRAP_EN
                    state_d = misalign ? ERR : REQ;
`else
                    state_d = REQ;
`endif
                end
            end
            REQ:  if (bus_ack) state_d = DONE;
            DONE: state_d = IDLE;
`ifdef RV32_LSU_MISALIGN_TRAP_EN
            ERR:  state_d = DONE;
`endif
            default: state_d = IDLE;
        endcase
    end

    // Stall depends only on state and the core request, never on the bus.
    always_comb begin
        stall = 1'b0;
        case (state_q)
            IDLE:    stall = req;
            REQ:     stall = 1'b1;
            DONE:    stall = 1'b0;
`ifdef RV32_LSU_MISALIGN_TRAP_EN
            ERR:     stall = 1'b1;
`endif
            default: stall = 1'b0;
        endcase
    end

    always_comb begin
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_be_d    = bus_be_q;
        bus_wdata_d = bus_wdata_q;
        rdata_d     = rdata_q;
        size_d      = size_q;
        sign_d      = sign_q;
        off_d       = off_q;
        store_d     = store_q;
`ifdef RV32_LSU_MISALIGN_TRAP_EN
        lsu_err_d   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (req) begin
                    bus_we_d    = MemWrite;
                    bus_addr_d  = {address[AW-1:2], 2'b00};
                    bus_be_d    = be_dec;
                    bus_wdata_d = wdata_dec;
                    size_d      = size_dec;
                    sign_d      = sign_dec;
                    off_d       = address[1:0];
                    store_d     = MemWrite;
                    rdata_d     = '0;
`ifdef RV32_LSU_MISALIGN_TRAP_EN
                    bus_req_d   = ~misalign;
`else
                    bus_req_d   = 1'b1;
`endif
                end
            end
            REQ: begin
                if (bus_ack) begin
                    bus_req_d = 1'b0;
                    rdata_d   = store_q ? '0 : load_ext;
                end
            end
`ifdef RV32_LSU_MISALIGN_TRAP_EN
            ERR: begin
                lsu_err_d = 1'b1;
                rdata_d   = '0;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_be_q    <= 4'b0000;
            bus_wdata_q <= '0;
            rdata_q     <= '0;
            size_q      <= SZ_WORD;
            sign_q      <= 1'b0;
            off_q       <= 2'b00;
            store_q     <= 1'b0;
`ifdef RV32_LSU_MISALIGN_TRAP_EN
            lsu_err_q   <= 1'b0;
`endif
        end else begin
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_be_q    <= bus_be_d;
            bus_wdata_q <= bus_wdata_d;
            rdata_q     <= rdata_d;
            size_q      <= size_d;
            sign_q      <= sign_d;
            off_q       <= off_d;
            store_q     <= store_d;
`ifdef RV32_LSU_MISALIGN_TRAP_EN
            lsu_err_q   <= lsu_err_d;
`endif
        end
    end

    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_be    = bus_be_q;
    assign bus_wdata = bus_wdata_q;
    assign rdata     = rdata_q;
`ifdef RV32_LSU_MISALIGN_TRAP_EN
    assign lsu_err   = lsu_err_q;
`else
    assign lsu_err   = 1'b0;
`endif

endmodule

// File: tb/tb_rv32_lsu.sv
// Directed self-checking bench for rv32_lsu; acts as both the core and a bus slave.
module tb_rv32_lsu;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] address;
    logic        MemRead;
    logic        MemWrite;
    logic [2:0]  funct3;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall;
    logic        lsu_err;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    int tests_run    = 0;
    int tests_failed = 0;

    // Results of the most recent run_access call.
    int          r_stall_cycles;
    int          r_err_cycles;
    int          r_req_cycles;
    logic        r_timeout;
    logic [31:0] r_rdata;
    logic [31:0] r_addr;
    logic [3:0]  r_be;
    logic [31:0] r_wdata;
    logic        r_we;

    always #5 clk = ~clk;

    rv32_lsu #(.AW(32), .DW(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .address   (address),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .funct3    (funct3),
        .wdata     (wdata),
        .rdata     (rdata),
        .stall     (stall),
        .lsu_err   (lsu_err),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_be    (bus_be),
        .bus_wdata (bus_wdata),
        .bus_ack   (bus_ack),
        .bus_rdata (bus_rdata)
    );

    // Presents one instruction until the core would retire it; acks after ack_delay low REQ cycles.
    task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wd,
                              input logic [31:0] slave_rd, input int ack_delay);
        logic finished;
        finished       = 1'b0;
        r_stall_cycles = 0;
        r_err_cycles   = 0;
        r_req_cycles   = 0;
        r_timeout      = 1'b0;
        r_rdata        = 32'hx;
        r_addr         = 32'hx;
        r_be           = 4'hx;
        r_wdata        = 32'hx;
        r_we           = 1'bx;
        @(negedge clk);
        MemRead   = rd;
        MemWrite  = wr;
        funct3    = f3;
        address   = addr;
        wdata     = wd;
        bus_rdata = slave_rd;
        bus_ack   = 1'b0;
        for (int c = 0; c < 64 && !finished; c++) begin
            #1;
            if (bus_req) begin
                r_req_cycles++;
                r_addr  = bus_addr;
                r_be    = bus_be;
                r_wdata = bus_wdata;
                r_we    = bus_we;
                bus_ack = (r_req_cycles > ack_delay);
            end else begin
                bus_ack = 1'b0;
            end
            if (lsu_err) r_err_cycles++;
            if (!stall) begin
                r_rdata  = rdata;
                finished = 1'b1;
            end else begin
                r_stall_cycles++;
                @(negedge clk);
            end
        end
        if (!finished) r_timeout = 1'b1;
        @(negedge clk);
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        bus_ack  = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        reset    = 1'b1;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        funct3   = 3'b010;
        address  = 32'h0;
        wdata    = 32'h0;
        bus_ack  = 1'b0;
        bus_rdata = 32'h0;
        repeat (3) @(negedge clk);
        #1;
        tests_run++;
        if (bus_req !== 1'b0 || bus_we !== 1'b0 || bus_addr !== 32'h0 ||
            bus_be !== 4'h0 || bus_wdata !== 32'h0) begin
            $display("[TB] FAIL reset_bus: got req=%b we=%b addr=%h be=%b wdata=%h, expected all zero",
                     bus_req, bus_we, bus_addr, bus_be, bus_wdata);
            tests_failed++;
        end
        tests_run++;
        if (rdata !== 32'h0 || lsu_err !== 1'b0 || stall !== 1'b0) begin
            $display("[TB] FAIL reset_core: got rdata=%h err=%b stall=%b, expected 0/0/0",
                     rdata, lsu_err, stall);
            tests_failed++;
        end
        MemRead = 1'b1;
        #1;
        tests_run++;
        if (stall !== 1'b1) begin
            $display("[TB] FAIL reset_stall_follows_req: got %b expected 1", stall);
            tests_failed++;
        end
        @(negedge clk);
        MemRead = 1'b0;
        reset   = 1'b0;
    endtask

    task automatic test_idle;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            tests_run++;
            if (stall !== 1'b0 || bus_req !== 1'b0) begin
                $display("[TB] FAIL idle_cycle%0d: got stall=%b bus_req=%b expected 0/0", i, stall, bus_req);
                tests_failed++;
            end
        end
    endtask

    task automatic test_store_word;
        run_access(1'b0, 1'b1, 3'b010, 32'h104, 32'hDEADBEEF, 32'h0, 0);
        tests_run++;
        if (r_timeout || r_addr !== 32'h104 || r_be !== 4'b1111 || r_wdata !== 32'hDEADBEEF || r_we !== 1'b1) begin
            $display("[TB] FAIL sw_bus: got to=%b addr=%h be=%b wdata=%h we=%b expected 104/1111/deadbeef/1",
                     r_timeout, r_addr, r_be, r_wdata, r_we);
            tests_failed++;
        end
        tests_run++;
        if (r_stall_cycles !== 2) begin
            $display("[TB] FAIL sw_stall: got %0d cycles expected 2", r_stall_cycles);
            tests_failed++;
        end
        tests_run++;
        if (bus_req !== 1'b0 || stall !== 1'b0) begin
            $display("[TB] FAIL sw_release: got bus_req=%b stall=%b expected 0/0", bus_req, stall);
            tests_failed++;
        end
    endtask

    task automatic test_store_byte_half;
        run_access(1'b0, 1'b1, 3'b000, 32'h203, 32'h000000A5, 32'h0, 0);
        tests_run++;
        if (r_addr !== 32'h200 || r_be !== 4'b1000 || r_wdata !== 32'hA5A5A5A5 || r_we !== 1'b1) begin
            $display("[TB] FAIL sb_bus: got addr=%h be=%b wdata=%h we=%b expected 200/1000/a5a5a5a5/1",
                     r_addr, r_be, r_wdata, r_we);
            tests_failed++;
        end
        run_access(1'b0, 1'b1, 3'b001, 32'h002, 32'h1234BEEF, 32'h0, 1);
        tests_run++;
        if (r_addr !== 32'h0 || r_be !== 4'b1100 || r_wdata !== 32'hBEEFBEEF || r_stall_cycles !== 3) begin
            $display("[TB] FAIL sh_bus: got addr=%h be=%b wdata=%h stall=%0d expected 0/1100/beefbeef/3",
                     r_addr, r_be, r_wdata, r_stall_cycles);
            tests_failed++;
        end
    endtask

    task automatic test_load_byte;
        run_access(1'b1, 1'b0, 3'b000, 32'h301, 32'h0, 32'h1122F044, 3);
        tests_run++;
        if (r_rdata !== 32'hFFFFFFF0 || r_addr !== 32'h300 || r_be !== 4'b0010 || r_we !== 1'b0) begin
            $display("[TB] FAIL lb_data: got rdata=%h addr=%h be=%b we=%b expected fffffff0/300/0010/0",
                     r_rdata, r_addr, r_be, r_we);
            tests_failed++;
        end
        tests_run++;
        if (r_stall_cycles !== 5) begin
            $display("[TB] FAIL lb_stall: got %0d cycles expected 5", r_stall_cycles);
            tests_failed++;
        end
        run_access(1'b1, 1'b0, 3'b100, 32'h301, 32'h0, 32'h1122F044, 3);
        tests_run++;
        if (r_rdata !== 32'h000000F0 || r_stall_cycles !== 5) begin
            $display("[TB] FAIL lbu_data: got rdata=%h stall=%0d expected 000000f0/5", r_rdata, r_stall_cycles);
            tests_failed++;
        end
    endtask

    task automatic test_load_half;
        run_access(1'b1, 1'b0, 3'b001, 32'h402, 32'h0, 32'h80017FFF, 0);
        tests_run++;
        if (r_rdata !== 32'hFFFF8001 || r_be !== 4'b1100 || r_addr !== 32'h400) begin
            $display("[TB] FAIL lh_data: got rdata=%h be=%b addr=%h expected ffff8001/1100/400",
                     r_rdata, r_be, r_addr);
            tests_failed++;
        end
        run_access(1'b1, 1'b0, 3'b101, 32'h402, 32'h0, 32'h80017FFF, 0);
        tests_run++;
        if (r_rdata !== 32'h00008001) begin
            $display("[TB] FAIL lhu_data: got %h expected 00008001", r_rdata);
            tests_failed++;
        end
        run_access(1'b1, 1'b0, 3'b001, 32'h400, 32'h0, 32'h80017FFF, 0);
        tests_run++;
        if (r_rdata !== 32'h00007FFF || r_be !== 4'b0011) begin
            $display("[TB] FAIL lh_low: got rdata=%h be=%b expected 00007fff/0011", r_rdata, r_be);
            tests_failed++;
        end
    endtask

    task automatic test_misalign;
        run_access(1'b1, 1'b0, 3'b010, 32'h105, 32'h0, 32'h12345678, 0);
`ifdef RV32_LSU_MISALIGN_TRAP_EN
        tests_run++;
        if (r_req_cycles !== 0 || r_err_cycles !== 1 || r_rdata !== 32'h0 || r_stall_cycles !== 2) begin
            $display("[TB] FAIL misalign_trap: got req=%0d err=%0d rdata=%h stall=%0d expected 0/1/0/2",
                     r_req_cycles, r_err_cycles, r_rdata, r_stall_cycles);
            tests_failed++;
        end
        tests_run++;
        if (lsu_err !== 1'b0) begin
            $display("[TB] FAIL misalign_err_pulse: got %b expected 0 after DONE", lsu_err);
            tests_failed++;
        end
`else
        tests_run++;
        if (r_addr !== 32'h104 || r_be !== 4'b1111 || r_rdata !== 32'h12345678 || r_err_cycles !== 0) begin
            $display("[TB] FAIL misalign_word: got addr=%h be=%b rdata=%h err=%0d expected 104/1111/12345678/0",
                     r_addr, r_be, r_rdata, r_err_cycles);
            tests_failed++;
        end
`endif
    endtask

    task automatic test_read_write_both;
        run_access(1'b1, 1'b1, 3'b010, 32'h010, 32'h55AA55AA, 32'hFFFFFFFF, 0);
        tests_run++;
        if (r_we !== 1'b1 || r_rdata !== 32'h0 || r_wdata !== 32'h55AA55AA) begin
            $display("[TB] FAIL both_is_store: got we=%b rdata=%h wdata=%h expected 1/0/55aa55aa",
                     r_we, r_rdata, r_wdata);
            tests_failed++;
        end
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        MemRead  = 1'b1;
        MemWrite = 1'b0;
        funct3   = 3'b010;
        address  = 32'h600;
        bus_ack  = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        tests_run++;
        if (bus_req !== 1'b1 || stall !== 1'b1) begin
            $display("[TB] FAIL rst_mid_req: got bus_req=%b stall=%b expected 1/1", bus_req, stall);
            tests_failed++;
        end
        reset   = 1'b1;
        MemRead = 1'b0;
        @(negedge clk);
        #1;
        tests_run++;
        if (bus_req !== 1'b0 || stall !== 1'b0) begin
            $display("[TB] FAIL rst_mid_drop: got bus_req=%b stall=%b expected 0/0", bus_req, stall);
            tests_failed++;
        end
        reset = 1'b0;
        run_access(1'b1, 1'b0, 3'b010, 32'h500, 32'h0, 32'hCAFEF00D, 1);
        tests_run++;
        if (r_timeout || r_rdata !== 32'hCAFEF00D || r_stall_cycles !== 3 || r_addr !== 32'h500) begin
            $display("[TB] FAIL rst_mid_after: got to=%b rdata=%h stall=%0d addr=%h expected 0/cafef00d/3/500",
                     r_timeout, r_rdata, r_stall_cycles, r_addr);
            tests_failed++;
        end
    endtask

    task automatic test_back_to_back;
        run_access(1'b0, 1'b1, 3'b000, 32'h701, 32'h0000003C, 32'h0, 0);
        run_access(1'b1, 1'b0, 3'b000, 32'h702, 32'h0, 32'h00800000, 0);
        tests_run++;
        if (r_rdata !== 32'hFFFFFF80 || r_be !== 4'b0100 || r_stall_cycles !== 2) begin
            $display("[TB] FAIL b2b_load: got rdata=%h be=%b stall=%0d expected ffffff80/0100/2",
                     r_rdata, r_be, r_stall_cycles);
            tests_failed++;
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_idle();
        test_store_word();
        test_store_byte_half();
        test_load_byte();
        test_load_half();
        test_misalign();
        test_read_write_both();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/rv32_lsu.md
# rv32_lsu

Load/store unit between the single-cycle RV32 core's data-memory port and a request/acknowledge data bus. It accepts one load or store per instruction from the core. It holds the core with `stall` while the bus transfer is outstanding. It generates byte enables and lane-replicated write data, and returns sign- or zero-extended load data. It is the downstream consumer of the core's `address`/`MemRead`/`MemWrite`/`wdata` outputs; the core gates its PC and register-file write with `stall`.

## Interface
- `AW`, 32, core/bus address width
- `DW`, 32, data width (fixed at 32 for RV32)
- `clk`  input  1  clock, all state updates on rising edge
- `reset`  input  1  synchronous, active-high reset
- `address`  input  AW  byte address from core ALU
- `MemRead`  input  1  core load request
- `MemWrite`  input  1  core store request
- `funct3`  input  3  access size/sign from instruction[14:12]
- `wdata`  input  DW  store data (rs2) from core
- `rdata`  output  DW  extended load data to core writeback mux
- `stall`  output  1  core must hold PC and suppress register write
- `lsu_err`  output  1  one-cycle pulse: access rejected
- `bus_req`  output  1  bus request, held until acked
- `bus_we`  output  1  1 = write, 0 = read
- `bus_addr`  output  AW  word-aligned address (`[1:0]` = 0)
- `bus_be`  output  4  byte lane enables
- `bus_wdata`  output  DW  lane-positioned write data
- `bus_ack`  input  1  slave completes transfer this cycle
- `bus_rdata`  input  DW  read data, valid when `bus_ack`=1

## Operation
- States: IDLE, REQ, DONE, plus ERR when `RV32_LSU_MISALIGN_TRAP_EN` is defined.
- `req` = `MemRead | MemWrite`. If both are set, the access is a store and `rdata` = 0.
- IDLE:
  - With `req`=1, `stall`=1 combinationally.
  - At the edge, latch address, size, sign, direction, lanes and data, then go to REQ.
  - In the ERR case, go to ERR instead.
- REQ:
  - `bus_req`=1 and `stall`=1; all bus fields are registered and stable.
  - On `bus_ack`=1, capture `bus_rdata` (loads) and go to DONE.
  - `bus_ack` in any other state is ignored.
- DONE:
  - `stall`=0 and `rdata` is valid from a register; the core retires the instruction at this edge.
  - No new request is accepted in DONE. Always return to IDLE.
- ERR: no bus transaction; go to DONE with `lsu_err`=1 during DONE and `rdata`=0.
- funct3 decode:
  - 000 = LB/SB, 001 = LH/SH, 010 = LW/SW, 100 = LBU, 101 = LHU.
  - 011/110/111 are treated as word access.
- Byte enables:
  - Byte: `1<<addr[1:0]`.
  - Half: `0011` if `addr[1]`=0, else `1100`.
  - Word: `1111`.
- Write data: byte is replicated on all 4 lanes; half is replicated on both halves.
- Load extract uses lane `addr[1:0]` (byte) or `addr[1]` (half). Sign-extend for 000/001; zero-extend for 100/101.
- `reset` in any state forces IDLE at the next edge, abandoning any transfer in flight. The slave must tolerate a dropped `bus_req`.
- Reset values: `bus_req`=0, `bus_we`=0, `bus_addr`=0, `bus_be`=0, `bus_wdata`=0, `rdata`=0, `lsu_err`=0, state IDLE. `stall` follows `req` combinationally.

## Timing
- Minimum access, with `bus_ack` in the first REQ cycle: 3 cycles (IDLE, REQ, DONE), of which `stall` is high for 2.
- Each extra cycle of `bus_ack` low adds one REQ cycle.
- `stall` depends combinationally on `MemRead`/`MemWrite`/state only, never on `bus_ack`. There is no bus-to-core combinational path.
- Non-memory instructions: `stall`=0 and the LSU stays in IDLE.

## Configuration
- `RV32_LSU_MISALIGN_TRAP_EN` defined:
  - A half access with `addr[0]`=1, or a word access with `addr[1:0]`≠0, enters ERR.
  - funct3 011/110/111 also enters ERR.
  - No bus cycle is issued and `lsu_err` pulses in DONE.
- Undefined:
  - No ERR state; `lsu_err` is tied to 0.
  - Misaligned low address bits are ignored: half uses `addr[1]`, word ignores `addr[1:0]`.
  - The access proceeds normally.

## Test plan
- SW `address`=0x104, `wdata`=0xDEADBEEF, `bus_ack` on first REQ cycle -> `bus_addr`=0x104, `bus_be`=1111, `bus_wdata`=0xDEADBEEF, `bus_we`=1; `stall` high for exactly 2 cycles.
- SB `address`=0x203, `wdata`=0x000000A5 -> `bus_addr`=0x200, `bus_be`=1000, `bus_wdata`=0xA5A5A5A5.
- LB/LBU `address`=0x301, `bus_rdata`=0x1122F044, with `bus_ack` delayed 3 cycles -> `rdata`=0xFFFFFFF0 (LB) and 0x000000F0 (LBU); `stall` high for 5 cycles.
- LH `address`=0x402, `bus_rdata`=0x8001_7FFF -> `rdata`=0xFFFF8001; LHU -> 0x00008001.
- With the macro, LW `address`=0x105 -> `bus_req` never asserts; `lsu_err`=1 for one cycle, `rdata`=0, `stall` high for 2 cycles. Without the macro, the same access reads word 0x104.
- Assert `reset` during REQ with `bus_ack` low -> next cycle `bus_req`=0, state IDLE; a subsequent LW completes normally.
